// File: rtl/reg_read_bank.sv
// ----------------------------------------------------------------------------
// reg_read_bank
//
// Decode-side register bank with a registered two-operand read stage.
// The write-back stage commits one write per cycle. Decode reads two operands
// per cycle, and both land in output registers that feed the ID/EX boundary.
//
// Read behaviour:
//   - A same-cycle write to the register being read is forwarded (write-first
//     bypass), so the new value appears after the same edge.
//   - Entry 0 always reads as zero.
//   - A stall (re=0) holds the operand registers.
//   - A flush squashes them to a bubble. Flush has priority over re.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-high reset (clears array and outputs)
//   we     in   write enable from write-back
//   waddr  in   [ADDR_W-1:0] write register index (index 0 is discarded)
//   wdata  in   [DATA_W-1:0] write data
//   re     in   read enable; low = stall, hold rd1/rd2/rvalid
//   flush  in   squash read stage: rd1/rd2 <= 0, rvalid <= 0
//   ra1    in   [ADDR_W-1:0] read port 1 index
//   ra2    in   [ADDR_W-1:0] read port 2 index
//   rd1    out  [DATA_W-1:0] registered operand 1
//   rd2    out  [DATA_W-1:0] registered operand 2
//   rvalid out  rd1/rd2 hold a valid captured read
// ----------------------------------------------------------------------------
module reg_read_bank #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic              flush,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              rvalid
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_commit;
    logic [DATA_W-1:0] sel1;
    logic [DATA_W-1:0] sel2;

    // Writes to index 0 are dropped, so entry 0 keeps its reset value of zero.
    assign wr_commit = we && (waddr != '0);

    // ------------------------------------------------------------------------
    // Register array
    // ------------------------------------------------------------------------
    // NOTE: the array is cleared on reset because the design requires every
    // entry to read zero after reset. This forces flip-flop storage rather
    // than a RAM macro, which is acceptable at this depth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                // NOTE: sequential state uses non-blocking assignments so that
                // every flop samples pre-edge values, whatever the block order.
                mem[i] <= '0;
            end
        end else if (wr_commit) begin
            mem[waddr] <= wdata;
        end
    end

    // ------------------------------------------------------------------------
    // Operand select: zero register, then write-first bypass, then the array.
    // The bypass compares against the raw write port. A write to index 0 is
    // already excluded because ra==0 is checked first.
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: each combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        sel1 = mem[ra1];
        if (ra1 == '0) begin
            sel1 = '0;
        end else if (we && (waddr == ra1)) begin
            sel1 = wdata;
        end
    end

    always_comb begin
        sel2 = mem[ra2];
        if (ra2 == '0) begin
            sel2 = '0;
        end else if (we && (waddr == ra2)) begin
            sel2 = wdata;
        end
    end

    // ------------------------------------------------------------------------
    // Output operand registers: flush > re > hold.
    // During a stall the held values are not refreshed by later writes.
    // Decode re-issues the read to pick up new data.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd1    <= '0;
            rd2    <= '0;
            rvalid <= 1'b0;
        end else if (flush) begin
            rd1    <= '0;
            rd2    <= '0;
            rvalid <= 1'b0;
        end else if (re) begin
            rd1    <= sel1;
            rd2    <= sel2;
            rvalid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_read_bank.sv
// ----------------------------------------------------------------------------
// tb_reg_read_bank
//
// Directed testbench for reg_read_bank. Each scenario task drives its stimulus
// and compares the DUT outputs against hand-computed values. The back-to-back
// stream uses a small golden model of the bank.
//
// Timing: inputs change 1 ns after a rising edge. Outputs are sampled at that
// same point, well away from the active edge.
// ----------------------------------------------------------------------------
module tb_reg_read_bank;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    logic              clk;
    logic              reset;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re;
    logic              flush;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              rvalid;

    int errors = 0;
    int checks = 0;

    reg_read_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk    (clk),
        .reset  (reset),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .re     (re),
        .flush  (flush),
        .ra1    (ra1),
        .ra2    (ra2),
        .rd1    (rd1),
        .rd2    (rd2),
        .rvalid (rvalid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog: the run is a fixed number of cycles, so this only fires if
    // simulation stops making progress.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time=%0t, required finish before 100000", $time);
        $fatal(1);
    end

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        re    = 1'b0;
        flush = 1'b0;
        ra1   = '0;
        ra2   = '0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        // Initial power-on reset.
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        step();
        checks++;
        if (rvalid !== 1'b0) begin
            errors++;
            $display("FAIL por_rvalid: got %b want 0", rvalid);
        end

        // Load rd1=5A through the bypass path, then reset mid-cycle.
        we = 1'b1; waddr = 3'd6; wdata = 8'h5A; ra1 = 3'd6; ra2 = 3'd6; re = 1'b1;
        step();
        checks++;
        if (rd1 !== 8'h5A) begin
            errors++;
            $display("FAIL pre_reset_rd1: got %h want 5a", rd1);
        end
        idle_inputs();
        #2;
        reset = 1'b1;
        #1;  // no clock edge between assertion and this sample
        checks++;
        if (rd1 !== 8'h00 || rd2 !== 8'h00 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got rd1=%h rd2=%h rvalid=%b want 00 00 0", rd1, rd2, rvalid);
        end
        #1;
        reset = 1'b0;
        step();

        // After reset, every index reads zero, including r6 written above.
        for (int i = 0; i < 8; i++) begin
            ra1 = 3'(i);
            ra2 = 3'(7 - i);
            re  = 1'b1;
            step();
            checks++;
            if (rd1 !== 8'h00 || rd2 !== 8'h00 || rvalid !== 1'b1) begin
                errors++;
                $display("FAIL post_reset_read[%0d]: got rd1=%h rd2=%h rvalid=%b want 00 00 1",
                         i, rd1, rd2, rvalid);
            end
        end
        idle_inputs();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_write_read();
        we = 1'b1; waddr = 3'd3; wdata = 8'hA5; re = 1'b0;
        step();
        idle_inputs();
        ra1 = 3'd3; ra2 = 3'd3; re = 1'b1;
        step();
        checks++;
        if (rd1 !== 8'hA5 || rd2 !== 8'hA5 || rvalid !== 1'b1) begin
            errors++;
            $display("FAIL write_read_r3: got rd1=%h rd2=%h rvalid=%b want a5 a5 1", rd1, rd2, rvalid);
        end
        idle_inputs();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_bypass_r0();
        // Same-cycle write of r5 is forwarded to port 1. Port 2 reads r0.
        we = 1'b1; waddr = 3'd5; wdata = 8'h3C; ra1 = 3'd5; ra2 = 3'd0; re = 1'b1;
        step();
        checks++;
        if (rd1 !== 8'h3C || rd2 !== 8'h00) begin
            errors++;
            $display("FAIL bypass_r5: got rd1=%h rd2=%h want 3c 00", rd1, rd2);
        end

        // A write to r0 must not bypass, and must not commit.
        we = 1'b1; waddr = 3'd0; wdata = 8'hFF; ra1 = 3'd0; ra2 = 3'd0; re = 1'b1;
        step();
        checks++;
        if (rd1 !== 8'h00 || rd2 !== 8'h00) begin
            errors++;
            $display("FAIL r0_bypass: got rd1=%h rd2=%h want 00 00", rd1, rd2);
        end
        we = 1'b0; ra1 = 3'd0; ra2 = 3'd5;
        step();
        checks++;
        if (rd1 !== 8'h00 || rd2 !== 8'h3C) begin
            errors++;
            $display("FAIL r0_readback: got rd1=%h rd2=%h want 00 3c", rd1, rd2);
        end

        // Both ports on the same register during a bypass.
        we = 1'b1; waddr = 3'd7; wdata = 8'h9E; ra1 = 3'd7; ra2 = 3'd7;
        step();
        checks++;
        if (rd1 !== 8'h9E || rd2 !== 8'h9E) begin
            errors++;
            $display("FAIL dual_bypass_r7: got rd1=%h rd2=%h want 9e 9e", rd1, rd2);
        end
        idle_inputs();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_stall();
        we = 1'b1; waddr = 3'd2; wdata = 8'h11; re = 1'b0;
        step();
        idle_inputs();
        ra1 = 3'd2; ra2 = 3'd3; re = 1'b1;
        step();
        checks++;
        if (rd1 !== 8'h11 || rd2 !== 8'hA5 || rvalid !== 1'b1) begin
            errors++;
            $display("FAIL stall_setup: got rd1=%h rd2=%h rvalid=%b want 11 a5 1", rd1, rd2, rvalid);
        end

        // Stall for three cycles while r2 is overwritten.
        for (int c = 0; c < 3; c++) begin
            re = 1'b0; we = 1'b1; waddr = 3'd2; wdata = 8'h22;
            step();
            checks++;
            if (rd1 !== 8'h11 || rd2 !== 8'hA5 || rvalid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got rd1=%h rd2=%h rvalid=%b want 11 a5 1",
                         c, rd1, rd2, rvalid);
            end
        end

        // Re-issue the read: the array now holds 22.
        we = 1'b0; re = 1'b1;
        step();
        checks++;
        if (rd1 !== 8'h22 || rvalid !== 1'b1) begin
            errors++;
            $display("FAIL stall_reissue: got rd1=%h rvalid=%b want 22 1", rd1, rvalid);
        end
        idle_inputs();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_flush();
        we = 1'b1; waddr = 3'd6; wdata = 8'h77; re = 1'b0;
        step();

        // Flush wins over re. The concurrent r4 write still commits.
        flush = 1'b1; re = 1'b1; ra1 = 3'd6; ra2 = 3'd6;
        we = 1'b1; waddr = 3'd4; wdata = 8'h44;
        step();
        checks++;
        if (rd1 !== 8'h00 || rd2 !== 8'h00 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL flush_priority: got rd1=%h rd2=%h rvalid=%b want 00 00 0", rd1, rd2, rvalid);
        end

        // A stall after a flush keeps the bubble.
        idle_inputs();
        ra1 = 3'd6;
        step();
        checks++;
        if (rd1 !== 8'h00 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL flush_then_stall: got rd1=%h rvalid=%b want 00 0", rd1, rvalid);
        end

        re = 1'b1; ra1 = 3'd4; ra2 = 3'd6;
        step();
        checks++;
        if (rd1 !== 8'h44 || rd2 !== 8'h77 || rvalid !== 1'b1) begin
            errors++;
            $display("FAIL flush_write_commit: got rd1=%h rd2=%h rvalid=%b want 44 77 1", rd1, rd2, rvalid);
        end
        idle_inputs();
    endtask

    // ------------------------------------------------------------------------
    // 16 consecutive cycles: write r1..r7 in rotation, read the previous write
    // index on port 1 (array path) and the current one on port 2 (bypass).
    // ------------------------------------------------------------------------
    task automatic test_back_to_back();
        logic [DATA_W-1:0] model [8];
        logic [ADDR_W-1:0] prev_idx;
        logic [ADDR_W-1:0] widx;
        logic [DATA_W-1:0] wd;
        logic [DATA_W-1:0] exp1;
        logic [DATA_W-1:0] exp2;

        // Port 1 only reads indices this stream has written (or r0 on the
        // first cycle), so the model starts from zero.
        for (int i = 0; i < 8; i++) model[i] = '0;
        prev_idx = '0;

        for (int c = 0; c < 16; c++) begin
            widx = 3'((c % 7) + 1);
            wd   = 8'(c * 19 + 33);

            exp1 = (prev_idx == 0) ? 8'h00 : ((prev_idx == widx) ? wd : model[prev_idx]);
            exp2 = wd;  // widx is never 0, so port 2 always takes the bypass

            we = 1'b1; waddr = widx; wdata = wd;
            re = 1'b1; flush = 1'b0;
            ra1 = prev_idx; ra2 = widx;
            step();

            model[widx] = wd;
            prev_idx    = widx;

            checks++;
            if (rd1 !== exp1 || rd2 !== exp2 || rvalid !== 1'b1) begin
                errors++;
                $display("FAIL b2b[%0d]: got rd1=%h rd2=%h rvalid=%b want %h %h 1",
                         c, rd1, rd2, rvalid, exp1, exp2);
            end
        end
        idle_inputs();
    endtask

    // ------------------------------------------------------------------------
    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_write_read();
        test_bypass_r0();
        test_stall();
        test_flush();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
